// File: rtl/ahbl_arbiter_2m.sv
// ahbl_arbiter_2m: two-master AHB-Lite arbiter sharing one slave-side bus.
// Losers are parked in a per-master pending register and stalled via HREADY.
// Ports: HCLK, HRESET (sync, active-high); M0_*/M1_* master address/data
// inputs with HREADY/HRDATA outputs; S_* slave-side address/data outputs
// with S_HREADY/S_HRDATA inputs.
// Build option: define AHBL_ARB_FIXED_PRIO_EN for fixed priority (M0 wins
// ties); otherwise ties are resolved round-robin.
module ahbl_arbiter_2m #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic [2:0]    M0_HSIZE,
    input  logic          M0_HWRITE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic [2:0]    M1_HSIZE,
    input  logic          M1_HWRITE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic [DW-1:0] M1_HRDATA,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic [2:0]    S_HSIZE,
    output logic          S_HWRITE,
    output logic [DW-1:0] S_HWDATA,
    input  logic          S_HREADY,
    input  logic [DW-1:0] S_HRDATA
);

    logic [1:0]    pend_v;
    logic [AW-1:0] pend_addr  [2];
    logic [2:0]    pend_size  [2];
    logic [1:0]    pend_write;
    logic          dp_v;
    logic          dp_own;
`ifndef AHBL_ARB_FIXED_PRIO_EN
    logic          last_gnt;
`endif

    // Last granted address controls, shown while the bus is idle.
    logic [AW-1:0] hold_addr;
    logic [2:0]    hold_size;
    logic          hold_write;

    logic [AW-1:0] live_addr  [2];
    logic [2:0]    live_size  [2];
    logic [1:0]    live_write;
    logic [1:0]    live_trans;
    logic [1:0]    m_ready;
    logic [1:0]    live_req;
    logic [1:0]    req;
    logic          gnt_v;
    logic          gnt;
    logic [AW-1:0] sel_addr;
    logic [2:0]    sel_size;
    logic          sel_write;
    logic          unused_htrans0;

    assign live_addr[0]    = M0_HADDR;
    assign live_addr[1]    = M1_HADDR;
    assign live_size[0]    = M0_HSIZE;
    assign live_size[1]    = M1_HSIZE;
    assign live_write      = {M1_HWRITE, M0_HWRITE};
    assign live_trans      = {M1_HTRANS[1], M0_HTRANS[1]};
    assign unused_htrans0  = ^{M1_HTRANS[0], M0_HTRANS[0]};

    // A pending master is stalled; the data-phase owner follows the slave.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            m_ready[m] = 1'b1;
            if (HRESET)
                m_ready[m] = 1'b1;
            else if (pend_v[m])
                m_ready[m] = 1'b0;
            else if (dp_v && (dp_own == m[0]))
                m_ready[m] = S_HREADY;
        end
    end

    assign live_req = HRESET ? 2'b00 : (live_trans & m_ready & ~pend_v);
    assign req      = HRESET ? 2'b00 : (pend_v | live_req);

    // The chosen request is shown on the bus even during slave wait
    // states so the address phase stays stable; it commits only when
    // S_HREADY is high.
    always_comb begin
        gnt_v = |req;
        gnt   = 1'b0;
        unique case (1'b1)
            (req == 2'b10): gnt = 1'b1;
`ifdef AHBL_ARB_FIXED_PRIO_EN
            (req == 2'b11): gnt = 1'b0;
`else
            (req == 2'b11): gnt = ~last_gnt;
`endif
            default:        gnt = 1'b0;
        endcase
    end

    always_comb begin
        sel_addr  = live_addr[gnt];
        sel_size  = live_size[gnt];
        sel_write = live_write[gnt];
        if (pend_v[gnt]) begin
            sel_addr  = pend_addr[gnt];
            sel_size  = pend_size[gnt];
            sel_write = pend_write[gnt];
        end
    end

    assign S_HTRANS  = gnt_v ? 2'b10 : 2'b00;
    assign S_HADDR   = gnt_v ? sel_addr  : hold_addr;
    assign S_HSIZE   = gnt_v ? sel_size  : hold_size;
    assign S_HWRITE  = gnt_v ? sel_write : hold_write;
    assign S_HWDATA  = dp_own ? M1_HWDATA : M0_HWDATA;
    assign M0_HREADY = m_ready[0];
    assign M1_HREADY = m_ready[1];
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_v     <= 2'b00;
            pend_write <= 2'b00;
            dp_v       <= 1'b0;
            dp_own     <= 1'b0;
`ifndef AHBL_ARB_FIXED_PRIO_EN
            last_gnt   <= 1'b1;
`endif
            hold_addr  <= '0;
            hold_size  <= '0;
            hold_write <= 1'b0;
            for (int m = 0; m < 2; m++) begin
                pend_addr[m] <= '0;
                pend_size[m] <= '0;
            end
        end else begin
            if (S_HREADY) begin
                dp_v <= gnt_v;
                if (gnt_v) begin
                    dp_own       <= gnt;
`ifndef AHBL_ARB_FIXED_PRIO_EN
                    last_gnt     <= gnt;
`endif
                    pend_v[gnt]  <= 1'b0;
                    hold_addr    <= sel_addr;
                    hold_size    <= sel_size;
                    hold_write   <= sel_write;
                end
            end
            // Any accepted live request that is not committed now is parked.
            for (int m = 0; m < 2; m++) begin
                if (live_req[m] && !(S_HREADY && gnt_v && (gnt == m[0]))) begin
                    pend_v[m]     <= 1'b1;
                    pend_addr[m]  <= live_addr[m];
                    pend_size[m]  <= live_size[m];
                    pend_write[m] <= live_write[m];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahbl_arbiter_2m.sv
// tb_ahbl_arbiter_2m: directed self-checking bench for ahbl_arbiter_2m.
// Expected grant order follows AHBL_ARB_FIXED_PRIO_EN when defined.
module tb_ahbl_arbiter_2m;

    logic        clk;
    logic        rst;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [1:0]  m0_trans, m1_trans;
    logic [2:0]  m0_size, m1_size;
    logic        m0_write, m1_write;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  s_trans;
    logic [2:0]  s_size;
    logic        s_write, s_ready;

    int checks = 0;
    int errors = 0;

    ahbl_arbiter_2m dut (
        .HCLK      (clk),
        .HRESET    (rst),
        .M0_HADDR  (m0_addr),
        .M0_HTRANS (m0_trans),
        .M0_HSIZE  (m0_size),
        .M0_HWRITE (m0_write),
        .M0_HWDATA (m0_wdata),
        .M0_HREADY (m0_ready),
        .M0_HRDATA (m0_rdata),
        .M1_HADDR  (m1_addr),
        .M1_HTRANS (m1_trans),
        .M1_HSIZE  (m1_size),
        .M1_HWRITE (m1_write),
        .M1_HWDATA (m1_wdata),
        .M1_HREADY (m1_ready),
        .M1_HRDATA (m1_rdata),
        .S_HADDR   (s_addr),
        .S_HTRANS  (s_trans),
        .S_HSIZE   (s_size),
        .S_HWRITE  (s_write),
        .S_HWDATA  (s_wdata),
        .S_HREADY  (s_ready),
        .S_HRDATA  (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_trans = 2'b00;
        m1_trans = 2'b00;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_ready = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (s_trans !== 2'b00 || s_addr !== 32'h0 || s_size !== 3'd0 ||
            s_write !== 1'b0 || m0_ready !== 1'b1 || m1_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: trans=%b addr=%h size=%0d wr=%b r0=%b r1=%b exp 00/0/0/0/1/1",
                     s_trans, s_addr, s_size, s_write, m0_ready, m1_ready);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        m0_addr = 32'h4000_0001; m0_trans = 2'b10; m0_write = 1'b1;
        m0_size = 3'd2;
        @(negedge clk);
        checks++;
        if (s_trans !== 2'b10 || s_addr !== 32'h4000_0001 || s_write !== 1'b1 ||
            s_size !== 3'd2 || m1_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_addr: trans=%b addr=%h wr=%b size=%0d r1=%b exp 10/40000001/1/2/1",
                     s_trans, s_addr, s_write, s_size, m1_ready);
        end
        tick();
        m0_trans = 2'b00; m0_wdata = 32'h0000_0001;
        @(negedge clk);
        checks++;
        if (s_wdata !== 32'h0000_0001 || s_trans !== 2'b00 || m1_ready !== 1'b1 ||
            m0_ready !== 1'b1 || s_addr !== 32'h4000_0001) begin
            errors++;
            $display("FAIL single_data: wdata=%h trans=%b r1=%b r0=%b addr=%h exp 1/00/1/1/40000001",
                     s_wdata, s_trans, m1_ready, m0_ready, s_addr);
        end
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        m0_addr = 32'h4000_0002; m0_trans = 2'b10; m0_write = 1'b1;
        m1_addr = 32'h2000_0002; m1_trans = 2'b10; m1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (s_addr !== 32'h4000_0002 || s_write !== 1'b1 || m1_ready !== 1'b1) begin
            errors++;
            $display("FAIL contend_first: addr=%h wr=%b r1=%b exp 40000002/1/1",
                     s_addr, s_write, m1_ready);
        end
        tick();
        idle();
        m0_wdata = 32'h0000_00AA;
        @(negedge clk);
        checks++;
        if (m1_ready !== 1'b0 || s_addr !== 32'h2000_0002 || s_trans !== 2'b10 ||
            s_write !== 1'b0 || s_wdata !== 32'h0000_00AA || m0_ready !== 1'b1) begin
            errors++;
            $display("FAIL contend_second: r1=%b addr=%h trans=%b wr=%b wdata=%h r0=%b exp 0/20000002/10/0/aa/1",
                     m1_ready, s_addr, s_trans, s_write, s_wdata, m0_ready);
        end
        tick();
        s_rdata = 32'h0000_0004;
        @(negedge clk);
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'h0000_0004 || s_trans !== 2'b00) begin
            errors++;
            $display("FAIL contend_read: r1=%b rdata=%h trans=%b exp 1/4/00",
                     m1_ready, m1_rdata, s_trans);
        end
        tick();
    endtask

    task automatic test_wait_states();
        do_reset();
        m0_addr = 32'h4000_0003; m0_trans = 2'b10; m0_write = 1'b1;
        m1_addr = 32'h0000_0001; m1_trans = 2'b10; m1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (s_addr !== 32'h4000_0003) begin
            errors++;
            $display("FAIL wait_grant0: addr=%h exp 40000003", s_addr);
        end
        tick();
        idle();
        s_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (s_addr !== 32'h0000_0001 || s_trans !== 2'b10 ||
                m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_low%0d: addr=%h trans=%b r0=%b r1=%b exp 1/10/0/0",
                         c, s_addr, s_trans, m0_ready, m1_ready);
            end
            tick();
        end
        s_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_addr !== 32'h0000_0001 || s_trans !== 2'b10 ||
            m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_rise: addr=%h trans=%b r0=%b r1=%b exp 1/10/1/0",
                     s_addr, s_trans, m0_ready, m1_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m1_ready !== 1'b1 || s_trans !== 2'b00) begin
            errors++;
            $display("FAIL wait_m1data: r1=%b trans=%b exp 1/00", m1_ready, s_trans);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr [8];
        int i0, i1, gcount, first, last;
        logic r0, r1;
`ifdef AHBL_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) begin
            exp_addr[k]     = 32'h1000 + k;
            exp_addr[k + 4] = 32'h2000 + k;
        end
`else
        for (int k = 0; k < 4; k++) begin
            exp_addr[2 * k]     = 32'h1000 + k;
            exp_addr[2 * k + 1] = 32'h2000 + k;
        end
`endif
        do_reset();
        i0 = 0; i1 = 0; gcount = 0; first = -1; last = -1;
        m0_write = 1'b1; m1_write = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            m0_trans = (i0 < 4) ? 2'b10 : 2'b00;
            m0_addr  = 32'h1000 + i0;
            m1_trans = (i1 < 4) ? 2'b10 : 2'b00;
            m1_addr  = 32'h2000 + i1;
            @(negedge clk);
            r0 = m0_ready;
            r1 = m1_ready;
            if (s_trans === 2'b10) begin
                if (gcount < 8) begin
                    checks++;
                    if (s_addr !== exp_addr[gcount]) begin
                        errors++;
                        $display("FAIL b2b_grant%0d: addr=%h exp %h",
                                 gcount, s_addr, exp_addr[gcount]);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                gcount++;
            end
            tick();
            if (r0 && i0 < 4) i0++;
            if (r1 && i1 < 4) i1++;
        end
        idle();
        checks++;
        if (gcount !== 8 || (last - first) !== 7 || i0 !== 4 || i1 !== 4) begin
            errors++;
            $display("FAIL b2b_count: grants=%0d span=%0d i0=%0d i1=%0d exp 8/7/4/4",
                     gcount, last - first, i0, i1);
        end
    endtask

    task automatic test_reset_pending();
        int busy;
        do_reset();
        m0_addr = 32'h4000_0005; m0_trans = 2'b10; m0_write = 1'b1;
        m1_addr = 32'h2000_0005; m1_trans = 2'b10; m1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (s_addr !== 32'h4000_0005 || m1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstp_setup: addr=%h r1=%b exp 40000005/1", s_addr, m1_ready);
        end
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_trans !== 2'b00 || m0_ready !== 1'b1 || m1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstp_during: trans=%b r0=%b r1=%b exp 00/1/1",
                     s_trans, m0_ready, m1_ready);
        end
        tick();
        rst = 1'b0;
        busy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s_trans !== 2'b00 || m0_ready !== 1'b1 || m1_ready !== 1'b1)
                busy++;
            tick();
        end
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL rstp_after: bad_cycles=%0d exp 0", busy);
        end
    endtask

    initial begin
        rst = 1'b1; s_ready = 1'b1; s_rdata = '0;
        m0_addr = '0; m0_trans = '0; m0_size = '0; m0_write = 1'b0; m0_wdata = '0;
        m1_addr = '0; m1_trans = '0; m1_size = '0; m1_write = 1'b0; m1_wdata = '0;
        test_reset();
        test_single();
        test_contention();
        test_wait_states();
        test_back_to_back();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahbl_arbiter_2m.md
Name: ahbl_arbiter_2m

Overview:
Two-master AHB-Lite arbiter. It shares a single AHB-Lite slave-side bus between master port M0 (CPU) and master port M1 (DMA/testbench master). It sits between the masters and the address decoder/slave mux. Losing requests are buffered in a per-master pending register, and that master is stalled via its HREADY, so masters need no bus-request signals.

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
HCLK  input  1  bus clock, all state updates on rising edge
HRESET  input  1  synchronous, active-high reset
M0_HADDR  input  AW  master 0 address
M0_HTRANS  input  2  master 0 transfer type (only bit 1 examined)
M0_HSIZE  input  3  master 0 size
M0_HWRITE  input  1  master 0 direction
M0_HWDATA  input  DW  master 0 write data
M0_HREADY  output  1  master 0 ready
M0_HRDATA  output  DW  master 0 read data
M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE, M1_HWDATA  input  same as M0  master 1
M1_HREADY  output  1  master 1 ready
M1_HRDATA  output  DW  master 1 read data
S_HADDR  output  AW  slave-side address
S_HTRANS  output  2  slave-side transfer type (10 or 00 only)
S_HSIZE  output  3  slave-side size
S_HWRITE  output  1  slave-side direction
S_HWDATA  output  DW  slave-side write data
S_HREADY  input  1  slave-side ready (from slave mux)
S_HRDATA  input  DW  slave-side read data

Behaviour:
- Clock is HCLK. Reset is HRESET: synchronous, active-high, single clock domain.
- Request: master m requests in a cycle when Mm_HTRANS[1]=1 and Mm_HREADY=1. The source is the live inputs, or the pending register if pend_v[m]=1. A pending master's live inputs are ignored.
- State:
  - pend_v[1:0] plus per-master pend_addr, pend_size and pend_write.
  - dp_v and dp_own, the data-phase owner.
  - last_gnt, the round-robin pointer.
- Grant: evaluated only when S_HREADY=1.
  - Single requester: it wins.
  - Both requesting: the master != last_gnt wins.
  - Winner drives S_HADDR/S_HSIZE/S_HWRITE, from pend_* if pending, else live. S_HTRANS=10.
  - No grant: S_HTRANS=00; S_HADDR/S_HSIZE/S_HWRITE hold their last granted values.
- On a rising edge with S_HREADY=1 and a grant to g:
  - dp_v<=1, dp_own<=g, last_gnt<=g, pend_v[g]<=0.
  - Any live requester that loses: pend_v<=1 and its address controls are captured.
- On a rising edge with S_HREADY=1 and no grant: dp_v<=0.
- On a rising edge with S_HREADY=0:
  - No grant; dp_* and pend_* unchanged.
  - A live request (accepted because that master's HREADY=1) is captured into pending.
- S_HWDATA = Mdp_own_HWDATA. Pending masters hold HWDATA stable, because from the master's view its address phase completed at capture.
- Mm_HREADY:
  - 0 if pend_v[m].
  - Else S_HREADY if dp_v and dp_own=m.
  - Else 1.
- M0_HRDATA = M1_HRDATA = S_HRDATA (broadcast; the master validates with its HREADY).
- Latency:
  - Uncontended transfer: zero added cycles, pass-through.
  - Contended loser: stalled for the winner's full data phase, plus its own.
- No starvation: a pending master always wins the next grant after the current winner.
- Reset: pend_v=0, dp_v=0, last_gnt=1 (M0 wins the first tie), S_HADDR=0, S_HTRANS=00, S_HSIZE=0, S_HWRITE=0, M0_HREADY=M1_HREADY=1.
- Reset mid-transfer: in-flight and pending transfers are discarded with no replay.
- HRESP, HBURST, HPROT and locked transfers are not supported.

Optional Feature:
AHBL_ARB_FIXED_PRIO_EN
- Defined: fixed priority. M0 always wins ties; last_gnt is unused. M1 may starve under continuous M0 traffic, which is acceptable for CPU-over-DMA systems.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
1. Only M0 writes 0x40000001, data 0x00000001, S_HREADY=1. Expect S_HTRANS=10 and S_HADDR=0x40000001 in the same cycle, S_HWDATA=0x00000001 the next cycle, and M1_HREADY=1 throughout.
2. After reset, M0 writes 0x40000002 and M1 reads 0x20000002 in the same cycle. Expect:
   - M0 is granted first.
   - M1 is captured; M1_HREADY=0 for 1 cycle.
   - S_HADDR=0x20000002 one cycle after M0's address.
   - M1 sees S_HRDATA=0x00000004 with M1_HREADY=1.
3. M0 data phase with S_HREADY held low 2 cycles while M1 requests 0x00000001. Expect:
   - M1's address is held on S_HADDR with S_HTRANS=10 until S_HREADY rises.
   - M0_HREADY tracks S_HREADY.
   - M1_HREADY=0 throughout.
4. Both masters issue 4 back-to-back NONSEQ transfers each. Expect the grant order M0, M1, M0, M1, M0, M1, M0, M1 and 8 slave transfers in 8 data phases.
5. Assert HRESET for 1 cycle while M1 is pending. Expect S_HTRANS=00, M0_HREADY=M1_HREADY=1, and no M1 transfer on the slave side afterwards.
6. With AHBL_ARB_FIXED_PRIO_EN defined, repeat scenario 4. Expect all 4 M0 grants, then all 4 M1 grants.
